// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: target selects and sequencer states.
package pc_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    SEQ      = 2'd0,
    BRANCH   = 2'd1,
    JUMP_ALU = 2'd2,
    JUMP_REG = 2'd3
  } pc_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_unit_target_sel.sv
// Candidate next-PC selection; flags any candidate that departs from the sequential path.
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic [XLEN-1:0]  pc,
  input  logic [SEL_W-1:0] pc_sel,
  input  logic             bcond,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  alu_out,
  output logic [XLEN-1:0]  candidate,
  output logic             redirect
);

  logic [XLEN-1:0] seq_pc;

  assign seq_pc = pc + XLEN'(STEP);

  always_comb begin
    candidate = seq_pc;
    unique case (pc_sel_e'(pc_sel))
      SEQ:      candidate = seq_pc;
      BRANCH:   candidate = bcond ? alu_out : seq_pc;
      JUMP_ALU: candidate = alu_result;
      JUMP_REG: candidate = {alu_out[XLEN-1:1], 1'b0};
      default:  candidate = seq_pc;
    endcase
  end

  assign redirect = (candidate != seq_pc);

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with stall-deferred redirects, misaligned-target trapping
// and an update counter.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     STEP       = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100),
  parameter int unsigned     CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pc_write,
  input  logic             stall,
  input  logic [SEL_W-1:0] pc_sel,
  input  logic             bcond,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             trap_req,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  next_pc,
  output logic             redirect_pending,
  output logic             misaligned,
  output logic [XLEN-1:0]  bad_target,
  output logic [CNT_W-1:0] upd_count
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q;
  logic            pc_we;
  logic            load;
  logic [XLEN-1:0] load_tgt;
  logic [XLEN-1:0] candidate;
  logic            redirect;

  pc_target_sel #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_target_sel (
    .pc         (pc_q),
    .pc_sel     (pc_sel),
    .bcond      (bcond),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .candidate  (candidate),
    .redirect   (redirect)
  );

  // Sequencer: trap first, then pending release, then fresh requests.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    bad_d    = bad_q;
    mis_d    = 1'b0;
    pc_we    = 1'b0;
    load     = 1'b0;
    load_tgt = candidate;

    if (trap_req) begin
      pc_d    = TRAP_VEC;
      pend_d  = '0;
      state_d = RUN;
      pc_we   = 1'b1;
    end else begin
      unique case (state_q)
        PEND: begin
          if (!stall) begin
            load     = 1'b1;
            load_tgt = pend_q;
            state_d  = RUN;
          end else if (pc_write && redirect) begin
            pend_d = candidate;
          end
        end
        RUN: begin
          if (pc_write) begin
            if (!stall) begin
              load     = 1'b1;
              load_tgt = candidate;
            end else if (redirect) begin
              pend_d  = candidate;
              state_d = PEND;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end

    // Misaligned loads divert to the trap vector instead.
    if (load) begin
      pc_we = 1'b1;
      if ((load_tgt & ALIGN_MASK) != '0) begin
        pc_d  = TRAP_VEC;
        bad_d = load_tgt;
        mis_d = 1'b1;
      end else begin
        pc_d = load_tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      bad_q   <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pc               = pc_q;
  assign next_pc          = candidate;
  assign redirect_pending = (state_q == PEND);
  assign misaligned       = mis_q;
  assign bad_target       = bad_q;
  assign upd_count        = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table through a scoreboard queue plus reset corner cases.
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_write;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        bcond;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic        trap_req;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect_pending;
  logic        misaligned;
  logic [31:0] bad_target;
  logic [31:0] upd_count;

  pc_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc_write         (pc_write),
    .stall            (stall),
    .pc_sel           (pc_sel),
    .bcond            (bcond),
    .alu_result       (alu_result),
    .alu_out          (alu_out),
    .trap_req         (trap_req),
    .pc               (pc),
    .next_pc          (next_pc),
    .redirect_pending (redirect_pending),
    .misaligned       (misaligned),
    .bad_target       (bad_target),
    .upd_count        (upd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
    logic [31:0] bad;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        pw;
    logic        st;
    logic [1:0]  sel;
    logic        bc;
    logic [31:0] ar;
    logic [31:0] ao;
    logic        tr;
    logic [31:0] npc;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pw, input logic st, input logic [1:0] sel, input logic bc,
                     input logic [31:0] ar, input logic [31:0] ao, input logic tr,
                     input logic [31:0] npc, input logic [31:0] epc, input logic ep,
                     input logic em, input logic [31:0] eb, input logic [31:0] ec);
    vec_t v;
    v.pw = pw; v.st = st; v.sel = sel; v.bc = bc; v.ar = ar; v.ao = ao; v.tr = tr;
    v.npc = npc;
    v.e.pc = epc; v.e.pend = ep; v.e.mis = em; v.e.bad = eb; v.e.cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    pc_write = 1'b0; stall = 1'b0; pc_sel = SEQ; bcond = 1'b0;
    alu_result = '0; alu_out = '0; trap_req = 1'b0;
  endtask

  task automatic check_state(input string tag, input exp_t e);
    chk({tag, ".pc"},   pc, e.pc);
    chk({tag, ".pend"}, 32'(redirect_pending), 32'(e.pend));
    chk({tag, ".mis"},  32'(misaligned), 32'(e.mis));
    chk({tag, ".bad"},  bad_target, e.bad);
    chk({tag, ".cnt"},  upd_count, e.cnt);
  endtask

  // Drive one vector at the falling edge, check the preview, then score after the rising edge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    pc_write = v.pw; stall = v.st; pc_sel = v.sel; bcond = v.bc;
    alu_result = v.ar; alu_out = v.ao; trap_req = v.tr;
    #1;
    chk($sformatf("v%0d.next_pc", idx), next_pc, v.npc);
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL v%0d.scoreboard: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      check_state($sformatf("v%0d", idx), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    //  pw st  sel       bc ar            ao            tr  npc           pc            pd mis bad          cnt
    add(1, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'h4,        32'h4,        0, 0, 32'h0,   32'd1);
    add(1, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'h8,        32'h8,        0, 0, 32'h0,   32'd2);
    add(1, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'hC,        32'hC,        0, 0, 32'h0,   32'd3);
    add(1, 0, JUMP_ALU, 0, 32'h40,       32'h0,        0, 32'h40,       32'h40,       0, 0, 32'h0,   32'd4);
    add(1, 0, BRANCH,   1, 32'h0,        32'h80,       0, 32'h80,       32'h80,       0, 0, 32'h0,   32'd5);
    add(1, 0, JUMP_ALU, 0, 32'h40,       32'h0,        0, 32'h40,       32'h40,       0, 0, 32'h0,   32'd6);
    add(1, 0, BRANCH,   0, 32'h0,        32'h80,       0, 32'h44,       32'h44,       0, 0, 32'h0,   32'd7);
    add(1, 0, JUMP_REG, 0, 32'h0,        32'h201,      0, 32'h200,      32'h200,      0, 0, 32'h0,   32'd8);
    add(1, 0, JUMP_ALU, 0, 32'h202,      32'h0,        0, 32'h202,      32'h100,      0, 1, 32'h202, 32'd9);
    add(0, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'h104,      32'h100,      0, 0, 32'h202, 32'd9);
    add(1, 1, JUMP_ALU, 0, 32'h300,      32'h0,        0, 32'h300,      32'h100,      1, 0, 32'h202, 32'd9);
    add(1, 1, JUMP_ALU, 0, 32'h400,      32'h0,        0, 32'h400,      32'h100,      1, 0, 32'h202, 32'd9);
    add(1, 1, SEQ,      0, 32'h0,        32'h0,        0, 32'h104,      32'h100,      1, 0, 32'h202, 32'd9);
    add(1, 0, JUMP_ALU, 0, 32'h500,      32'h0,        0, 32'h500,      32'h400,      0, 0, 32'h202, 32'd10);
    add(1, 1, SEQ,      0, 32'h0,        32'h0,        0, 32'h404,      32'h400,      0, 0, 32'h202, 32'd10);
    add(1, 1, BRANCH,   1, 32'h0,        32'h600,      0, 32'h600,      32'h400,      1, 0, 32'h202, 32'd10);
    add(0, 1, SEQ,      0, 32'h0,        32'h0,        1, 32'h404,      32'h100,      0, 0, 32'h202, 32'd11);
    add(0, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'h104,      32'h100,      0, 0, 32'h202, 32'd11);
    add(1, 1, JUMP_ALU, 0, 32'h2,        32'h0,        0, 32'h2,        32'h100,      1, 0, 32'h202, 32'd11);
    add(0, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'h104,      32'h100,      0, 1, 32'h2,   32'd12);
    add(1, 0, JUMP_ALU, 0, 32'h700,      32'h0,        1, 32'h700,      32'h100,      0, 0, 32'h2,   32'd13);
    add(1, 0, JUMP_REG, 0, 32'h0,        32'h303,      0, 32'h302,      32'h100,      0, 1, 32'h302, 32'd14);
    add(1, 0, JUMP_ALU, 0, 32'hFFFFFFFC, 32'h0,        0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 32'h302, 32'd15);
    add(1, 0, SEQ,      0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h302, 32'd16);

    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e.pc = 32'h0; e.pend = 1'b0; e.mis = 1'b0; e.bad = 32'h0; e.cnt = 32'h0;
    check_state("reset", e);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Asynchronous reset while a redirect is pending.
    @(negedge clk);
    pc_write = 1'b1; stall = 1'b1; pc_sel = JUMP_ALU; alu_result = 32'h300;
    @(posedge clk);
    #1;
    chk("arst.pre_pend", 32'(redirect_pending), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    e.pc = 32'h0; e.pend = 1'b0; e.mis = 1'b0; e.bad = 32'h0; e.cnt = 32'h0;
    check_state("arst", e);
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.lost_pc", pc, 32'h0);
    chk("arst.lost_pend", 32'(redirect_pending), 32'd0);

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle RISC-V core. It replaces the stand-alone next-PC mux with a block that owns the PC register and selects the next PC from sequential, branch and jump sources. It also defers redirects that arrive during a stall, traps misaligned targets and counts PC updates. It sits between the control FSM (pc_write, pc_sel), the ALU/ALUOut register (targets) and the instruction-memory address port.

## Interface
- XLEN, 32: PC and target width.
- RESET_PC, 0: PC value after reset.
- STEP, 4: sequential increment in bytes.
- ALIGN_BITS, 2: low target bits that must be zero.
- TRAP_VEC, 32'h100: PC loaded on trap or misalignment.
- CNT_W, 32: update-counter width.

- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- pc_write  in  1  control FSM requests a PC update this cycle.
- stall  in  1  hold PC; a redirect requested while stalled is deferred.
- pc_sel  in  2  target select: SEQ=0, BRANCH=1, JUMP_ALU=2, JUMP_REG=3.
- bcond  in  1  branch condition from ALU; used only when pc_sel=BRANCH.
- alu_result  in  XLEN  combinational ALU result (JAL target).
- alu_out  in  XLEN  registered ALUOut (branch target, JALR target).
- trap_req  in  1  external trap request.
- pc  out  XLEN  current PC; reset RESET_PC.
- next_pc  out  XLEN  combinational candidate target (preview only).
- redirect_pending  out  1  deferred redirect held; reset 0.
- misaligned  out  1  one-cycle pulse after a misaligned-target trap; reset 0.
- bad_target  out  XLEN  last misaligned target; reset 0.
- upd_count  out  CNT_W  number of PC updates; reset 0.

## Operation
Candidate target selection:
- SEQ gives pc+STEP.
- BRANCH gives alu_out if bcond, otherwise pc+STEP.
- JUMP_ALU gives alu_result.
- JUMP_REG gives alu_out with bit 0 forced to 0.
- A redirect is any candidate not equal to pc+STEP.

Sequencing is a state machine with RUN and PEND states. Actions in priority order:
1. trap_req=1: pc<=TRAP_VEC; the pending target is discarded; state<=RUN. Overrides stall.
2. State PEND and stall=0: pc<=pend_tgt; state<=RUN. pc_write in this cycle is ignored.
3. State PEND, stall=1, pc_write=1 with a redirect: pend_tgt is overwritten (newest wins).
4. State RUN, pc_write=1, stall=0: pc<=candidate.
5. State RUN, pc_write=1, stall=1:
   - If the candidate is a redirect: pend_tgt<=candidate; state<=PEND.
   - Sequential requests are dropped.
6. Otherwise pc holds.

Misalignment:
- Applies when the target about to be loaded in step 2 or 4 has a nonzero bit in [ALIGN_BITS-1:0].
- Instead of loading it: pc<=TRAP_VEC, bad_target<=target, and misaligned=1 next cycle.
- TRAP_VEC itself is never checked.

Other rules:
- redirect_pending = (state==PEND).
- upd_count increments by 1 on every cycle pc is written (cases 1, 2, 4, or a misalignment trap). It wraps modulo 2^CNT_W.
- All additions are XLEN-bit and wrap; pc+STEP at the top of the address space wraps to 0.

## Timing
- reset_n low asynchronously forces: pc=RESET_PC, state RUN, pend_tgt=0, misaligned=0, bad_target=0, upd_count=0. This applies mid-operation too; a pending redirect is lost.
- next_pc has zero latency (combinational from the inputs and pc).
- pc reflects the selected target one clock after the qualifying edge.
- misaligned is high exactly for the cycle after the trapping edge.
- A deferred redirect appears on pc on the first edge where stall=0.
- trap_req together with stall=0 and pc_write=1: the trap wins and the candidate is dropped.

## Structure
- pc_pkg holds the pc_sel encodings (SEQ, BRANCH, JUMP_ALU, JUMP_REG) and the state enum (RUN, PEND).
- One combinational sub-module, pc_target_sel, computes the candidate and the redirect flag.
- pc_unit holds the PC register, the state machine, pend_tgt, the misalignment logic and the counter.

## Test plan
- Reset, then pc_write=1, pc_sel=SEQ for 3 cycles -> pc: 0, 4, 8, 12; upd_count=3.
- pc=0x40, pc_sel=BRANCH, alu_out=0x80: with bcond=1 -> pc=0x80; repeated with bcond=0 -> pc=0x44.
- pc_sel=JUMP_REG with alu_out=0x201 -> pc=0x200. pc_sel=JUMP_ALU with alu_result=0x202 -> pc=0x100, misaligned pulses 1 cycle, bad_target=0x202.
- stall=1 and pc_write=1, JUMP_ALU target 0x300 -> pc unchanged, redirect_pending=1. Then a second redirect to 0x400 while still stalled. Then stall=0 -> pc=0x400, redirect_pending=0.
- With a redirect pending, assert trap_req=1 while stall=1 -> pc=0x100, redirect_pending=0.
- Pull reset_n low mid-clock-period while in PEND -> pc=0 and redirect_pending=0 immediately, before the next edge.
